// File: rtl/audio_gain_stage.sv
// Stereo gain/mute stage: per-channel unsigned Q1.(GW-1) gain, floor rounding, saturation, sticky clip flags.
// Latency: 2 clk from input handshake to out_valid; full throughput, one sample pair per clk.
// Backpressure: whole pipeline advances only when !out_valid | out_ready; in_ready mirrors that enable.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ready    {left, right} samples from the source
//   out_data/out_valid/out_ready scaled {left, right} samples to the FIFO
//   gain_l/gain_r/gain_load      target gains, loaded on a 1-clk pulse
//   mute                     level, zeroes both channels (captured with the sample)
//   clip_clr/clip_l/clip_r   sticky saturation flags and their clear pulse
//
// Optional feature: define AUDIO_GAIN_RAMP_EN to make the current gain walk toward
// the target by 1 LSB per accepted sample instead of jumping on gain_load.

module audio_gain_stage #(
    parameter int DW = 24,
    parameter int GW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [2*DW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic [GW-1:0]   gain_l,
    input  logic [GW-1:0]   gain_r,
    input  logic            gain_load,
    input  logic            mute,
    input  logic            clip_clr,
    output logic            clip_l,
    output logic            clip_r
);

    localparam int PW = DW + GW + 1;
    localparam logic [GW-1:0] UNITY = {1'b1, {(GW-1){1'b0}}};
    localparam logic signed [PW-1:0] YMAX = {{(GW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] YMIN = {{(GW+2){1'b1}}, {(DW-1){1'b0}}};

    // Returns {clip, y}: floor(x*g / 2**(GW-1)) saturated to DW bits.
    function automatic logic [DW:0] scale(input logic [DW-1:0] x, input logic [GW-1:0] g);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] y;
        p = $signed(x) * $signed({1'b0, g});
        y = p >>> (GW - 1);
        if (y > YMAX)
            scale = {1'b1, 1'b0, {(DW-1){1'b1}}};
        else if (y < YMIN)
            scale = {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            scale = {1'b0, y[DW-1:0]};
    endfunction

    logic            en;
    logic [GW-1:0]   tgt_l, tgt_r;
    logic [GW-1:0]   cur_l, cur_r;

    logic [2*DW-1:0] s1_data;
    logic [GW-1:0]   s1_gl, s1_gr;
    logic            s1_mute;
    logic            s1_valid;

    logic [DW-1:0]   y_l, y_r;
    logic            sat_l, sat_r;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Target gain registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_l <= UNITY;
            tgt_r <= UNITY;
        end else if (gain_load) begin
            tgt_l <= gain_l;
            tgt_r <= gain_r;
        end
    end

`ifdef AUDIO_GAIN_RAMP_EN
    logic accept;
    assign accept = in_valid && en;

    // The accepted sample takes the pre-step gain; the step applies to the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_l <= UNITY;
            cur_r <= UNITY;
        end else if (accept) begin
            if (cur_l < tgt_l)
                cur_l <= cur_l + 1'b1;
            else if (cur_l > tgt_l)
                cur_l <= cur_l - 1'b1;
            if (cur_r < tgt_r)
                cur_r <= cur_r + 1'b1;
            else if (cur_r > tgt_r)
                cur_r <= cur_r - 1'b1;
        end
    end
`else
    assign cur_l = tgt_l;
    assign cur_r = tgt_r;
`endif

    // Stage-2 arithmetic on the S1 snapshot
    always_comb begin
        {sat_l, y_l} = scale(s1_data[2*DW-1:DW], s1_gl);
        {sat_r, y_r} = scale(s1_data[DW-1:0], s1_gr);
        if (s1_mute) begin
            y_l   = '0;
            y_r   = '0;
            sat_l = 1'b0;
            sat_r = 1'b0;
        end
    end

    // Pipeline: gain and mute travel with the sample so a pair is never split.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data   <= '0;
            s1_gl     <= UNITY;
            s1_gr     <= UNITY;
            s1_mute   <= 1'b0;
            s1_valid  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            s1_data   <= in_data;
            s1_gl     <= cur_l;
            s1_gr     <= cur_r;
            s1_mute   <= mute;
            s1_valid  <= in_valid;
            out_data  <= {y_l, y_r};
            out_valid <= s1_valid;
        end
    end

    // Sticky clip flags: a new clip beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_l <= 1'b0;
            clip_r <= 1'b0;
        end else begin
            if (en && s1_valid && sat_l)
                clip_l <= 1'b1;
            else if (clip_clr)
                clip_l <= 1'b0;
            if (en && s1_valid && sat_r)
                clip_r <= 1'b1;
            else if (clip_clr)
                clip_r <= 1'b0;
        end
    end

endmodule
